convpress_dispatcher_d2: RTL and testbench

Per-lane dispatcher that runs the eDRAM-to-node direction of the compressed neuron stream: it accepts (value, offset) pairs for nonzero neurons from eDRAM and writes them into each lane's NBin and offset SRAM entries. Each lane has its own ring-buffer pointers. The block also counts completed bricks per lane and raises a node-level brick-available flag only when every lane holds a whole brick. It sits between eDRAM and the M0 NBin/offset buffers of the convpress node, upstream of the multiplier array.

---
 rtl/convpress_d2_pkg.sv | 19 +
 rtl/convpress_dispatch_lane.sv | 109 ++++++++++
 rtl/convpress_dispatcher_d2.sv | 82 ++++++++
 tb/tb_convpress_dispatcher_d2.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/convpress_d2_pkg.sv
// Shared defaults and helpers for the convpress eDRAM-to-node dispatcher.
package convpress_d2_pkg;

  localparam int DEF_N            = 16;
  localparam int DEF_TN           = 16;
  localparam int DEF_ADDR_SZ      = 6;
  localparam int DEF_OFFSET_SZ    = 4;
  localparam int DEF_BRICK_CNT_SZ = 2;

  // Entries per lane ring buffer and the width needed to count 0..DEPTH.
  localparam int DEPTH  = 2 ** DEF_ADDR_SZ;
  localparam int OCC_SZ = DEF_ADDR_SZ + 1;

  // Lowest bit of lane `lane` inside a flat bus of `width`-bit lane fields.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/convpress_dispatch_lane.sv
// One lane of the dispatcher: ring-buffer pointers, occupancy, completed
// brick count, the ready decision and the registered NBin/offset write port.
module convpress_dispatch_lane
  import convpress_d2_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int ADDR_SZ      = DEF_ADDR_SZ,
  parameter int OFFSET_SZ    = DEF_OFFSET_SZ,
  parameter int BRICK_CNT_SZ = DEF_BRICK_CNT_SZ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic                 i_null,
  input  logic [N-1:0]         i_data,
  input  logic [OFFSET_SZ-1:0] i_offset,
  input  logic                 i_pop,
  input  logic                 i_consume,     // already qualified by brick_avail
  output logic                 o_ready,
  output logic                 o_wen,
  output logic [ADDR_SZ-1:0]   o_addr,
  output logic [N-1:0]         o_data,
  output logic [OFFSET_SZ-1:0] o_offset,
  output logic [ADDR_SZ:0]     o_occ,
  output logic                 o_brick_held
);

  // Occupancy value of a completely full lane (exactly 2**ADDR_SZ).
  localparam logic [ADDR_SZ:0]      OCC_FULL = {1'b1, {ADDR_SZ{1'b0}}};
  // Highest brick count the lane may hold before it stops accepting.
  localparam logic [BRICK_CNT_SZ-1:0] BCNT_MAX = '1;

  logic                    run_q;
  logic [ADDR_SZ-1:0]      wptr_q;
  logic [ADDR_SZ-1:0]      rptr_q;
  logic [ADDR_SZ:0]        occ_q;
  logic [BRICK_CNT_SZ-1:0] bcnt_q;

  logic                    wen_q;
  logic [ADDR_SZ-1:0]      addr_q;
  logic [N-1:0]            data_q;
  logic [OFFSET_SZ-1:0]    off_q;

  logic ready;
  logic accept;
  logic null_beat;
  logic push;
  logic pop;
  logic brick_in;

  // run_q keeps ready low while in reset and for the edge that ends it.
  assign ready     = run_q & (occ_q < OCC_FULL) & (bcnt_q != BCNT_MAX);
  assign accept    = i_valid & ready;
  // A null flag only means "empty brick" when it closes the brick.
  assign null_beat = i_null & i_last;
  assign push      = accept & ~null_beat;
  assign pop       = i_pop & (occ_q != '0);
  assign brick_in  = accept & i_last;

  // Ring pointers, occupancy and completed-brick count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      bcnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      // A brick arriving and one being consumed in the same cycle cancel.
      if (brick_in && !i_consume)      bcnt_q <= bcnt_q + 1'b1;
      else if (!brick_in && i_consume) bcnt_q <= bcnt_q - 1'b1;
    end
  end

  // Registered write port: one cycle after acceptance, at the old wptr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      off_q  <= '0;
    end else begin
      wen_q <= push;
      if (push) begin
        addr_q <= wptr_q;
        data_q <= i_data;
        off_q  <= i_offset;
      end
    end
  end

  assign o_ready      = ready;
  assign o_wen        = wen_q;
  assign o_addr       = addr_q;
  assign o_data       = data_q;
  assign o_offset     = off_q;
  assign o_occ        = occ_q;
  assign o_brick_held = (bcnt_q != '0);

endmodule

// File: rtl/convpress_dispatcher_d2.sv
// Dispatcher for the eDRAM-to-node direction of the compressed neuron stream:
// Tn independent lanes write (value, offset) pairs into NBin/offset buffers,
// and the node sees a brick as available only when every lane holds one.
//
// Handshake: per lane, a beat transfers on a rising edge where
// i_valid[l] & o_ready[l]. o_ready[l] is driven from registered state only and
// never looks at i_valid[l]; the source holds the beat stable until it transfers.
module convpress_dispatcher_d2
  import convpress_d2_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int Tn           = DEF_TN,
  parameter int ADDR_SZ      = DEF_ADDR_SZ,
  parameter int OFFSET_SZ    = DEF_OFFSET_SZ,
  parameter int BRICK_CNT_SZ = DEF_BRICK_CNT_SZ
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Tn-1:0]                i_valid,
  input  logic [Tn-1:0]                i_last,
  input  logic [Tn-1:0]                i_null,
  input  logic [Tn*N-1:0]              i_data,
  input  logic [Tn*OFFSET_SZ-1:0]      i_offset,
  output logic [Tn-1:0]                o_ready,
  output logic [Tn*N-1:0]              o_nbin_data,
  output logic [Tn*OFFSET_SZ-1:0]      o_offset_data,
  output logic [Tn-1:0]                o_nbin_wen,
  output logic [Tn-1:0]                o_off_wen,
  output logic [Tn*ADDR_SZ-1:0]        o_nbin_addr,
  output logic [Tn*ADDR_SZ-1:0]        o_off_wr_addr,
  input  logic [Tn-1:0]                i_pop,
  output logic [Tn*(ADDR_SZ+1)-1:0]    o_occupancy,
  output logic                         o_brick_avail,
  input  logic                         i_brick_consume
);

  localparam int LANE_OCC_SZ = ADDR_SZ + 1;

  logic [Tn-1:0]         wen;
  logic [Tn*ADDR_SZ-1:0] addr;
  logic [Tn-1:0]         brick_held;
  logic                  brick_avail;
  logic                  consume;

  assign brick_avail = &brick_held;
  // Consume only counts when every lane really has a brick to give up.
  assign consume     = i_brick_consume & brick_avail;

  for (genvar l = 0; l < Tn; l++) begin : g_lane
    convpress_dispatch_lane #(
      .N            (N),
      .ADDR_SZ      (ADDR_SZ),
      .OFFSET_SZ    (OFFSET_SZ),
      .BRICK_CNT_SZ (BRICK_CNT_SZ)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid[l]),
      .i_last       (i_last[l]),
      .i_null       (i_null[l]),
      .i_data       (i_data[lane_lsb(l, N) +: N]),
      .i_offset     (i_offset[lane_lsb(l, OFFSET_SZ) +: OFFSET_SZ]),
      .i_pop        (i_pop[l]),
      .i_consume    (consume),
      .o_ready      (o_ready[l]),
      .o_wen        (wen[l]),
      .o_addr       (addr[lane_lsb(l, ADDR_SZ) +: ADDR_SZ]),
      .o_data       (o_nbin_data[lane_lsb(l, N) +: N]),
      .o_offset     (o_offset_data[lane_lsb(l, OFFSET_SZ) +: OFFSET_SZ]),
      .o_occ        (o_occupancy[lane_lsb(l, LANE_OCC_SZ) +: LANE_OCC_SZ]),
      .o_brick_held (brick_held[l])
    );
  end

  // NBin and offset SRAMs are written in lockstep from the same port.
  assign o_nbin_wen    = wen;
  assign o_off_wen     = wen;
  assign o_nbin_addr   = addr;
  assign o_off_wr_addr = addr;
  assign o_brick_avail = brick_avail;

endmodule

// File: tb/tb_convpress_dispatcher_d2.sv
// Directed bench for convpress_dispatcher_d2 with a write scoreboard.
module tb_convpress_dispatcher_d2;

  localparam int W = 30;  // {lane[3:0], addr[5:0], data[15:0], offset[3:0]}

  logic         clk;
  logic         rst;
  logic [15:0]  i_valid;
  logic [15:0]  i_last;
  logic [15:0]  i_null;
  logic [255:0] i_data;
  logic [63:0]  i_offset;
  logic [15:0]  o_ready;
  logic [255:0] o_nbin_data;
  logic [63:0]  o_offset_data;
  logic [15:0]  o_nbin_wen;
  logic [15:0]  o_off_wen;
  logic [95:0]  o_nbin_addr;
  logic [95:0]  o_off_wr_addr;
  logic [15:0]  i_pop;
  logic [111:0] o_occupancy;
  logic         o_brick_avail;
  logic         i_brick_consume;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;

  convpress_dispatcher_d2 dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .i_last          (i_last),
    .i_null          (i_null),
    .i_data          (i_data),
    .i_offset        (i_offset),
    .o_ready         (o_ready),
    .o_nbin_data     (o_nbin_data),
    .o_offset_data   (o_offset_data),
    .o_nbin_wen      (o_nbin_wen),
    .o_off_wen       (o_off_wen),
    .o_nbin_addr     (o_nbin_addr),
    .o_off_wr_addr   (o_off_wr_addr),
    .i_pop           (i_pop),
    .o_occupancy     (o_occupancy),
    .o_brick_avail   (o_brick_avail),
    .i_brick_consume (i_brick_consume)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] occ_of(input int l);
    return o_occupancy[l*7 +: 7];
  endfunction

  // One beat on lane l; returns 1 ns after the edge that took it.
  task automatic send(input int l, input bit last, input bit nul, input logic [15:0] d,
                      input logic [3:0] off, input logic [5:0] addr, input bit wr);
    logic [3:0] ln;
    ln = l[3:0];
    chk("ready_before_beat", 128'(o_ready[l]), 128'(1));
    i_valid[l] = 1'b1;
    i_last[l]  = last;
    i_null[l]  = nul;
    i_data[l*16 +: 16]  = d;
    i_offset[l*4 +: 4]  = off;
    if (wr) exp_q.push_back({ln, addr, d, off});
    @(posedge clk); #1;
    i_valid[l] = 1'b0;
    i_last[l]  = 1'b0;
    i_null[l]  = 1'b0;
  endtask

  task automatic null_beats(input logic [15:0] mask);
    i_valid = mask;
    i_last  = mask;
    i_null  = mask;
    @(posedge clk); #1;
    i_valid = '0;
    i_last  = '0;
    i_null  = '0;
  endtask

  task automatic consume();
    i_brick_consume = 1'b1;
    @(posedge clk); #1;
    i_brick_consume = 1'b0;
  endtask

  task automatic pop(input int l);
    i_pop[l] = 1'b1;
    @(posedge clk); #1;
    i_pop[l] = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("wen_pair", 128'(o_off_wen), 128'(o_nbin_wen));
      chk("addr_pair", 128'(o_off_wr_addr), 128'(o_nbin_addr));
      for (int l = 0; l < 16; l++) begin
        if (o_nbin_wen[l]) begin
          mon_act = {l[3:0], o_nbin_addr[l*6 +: 6], o_nbin_data[l*16 +: 16], o_offset_data[l*4 +: 4]};
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_unexpected: got entry 0x%0h on lane %0d, required no write", mon_act, l);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("write_entry", 128'(mon_act), 128'(mon_exp));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    i_valid = '0; i_last = '0; i_null = '0; i_pop = '0;
    i_data = '0; i_offset = '0; i_brick_consume = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(o_ready), 128'(0));
    chk("reset_avail", 128'(o_brick_avail), 128'(0));
    chk("reset_occ", 128'(o_occupancy), 128'(0));
    chk("reset_wen", 128'(o_nbin_wen), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 128'(o_ready), 128'(16'hFFFF));

    // Two-beat brick on lane 0.
    send(0, 1'b0, 1'b0, 16'h0011, 4'd3, 6'd0, 1'b1);
    send(0, 1'b1, 1'b0, 16'h0022, 4'd7, 6'd1, 1'b1);
    chk("lane0_wen", 128'(o_nbin_wen), 128'(16'h0001));
    chk("lane0_occ", 128'(occ_of(0)), 128'(2));
    chk("avail_one_lane", 128'(o_brick_avail), 128'(0));

    // All-zero bricks everywhere: no writes, node brick available.
    null_beats(16'hFFFF);
    chk("null_no_wen", 128'(o_nbin_wen), 128'(0));
    chk("avail_all_lanes", 128'(o_brick_avail), 128'(1));
    consume();
    chk("avail_after_consume", 128'(o_brick_avail), 128'(0));
    chk("occ0_kept", 128'(occ_of(0)), 128'(2));

    // Consume with nothing available must leave lane 0 at one brick.
    consume();
    null_beats(16'hFFFE);
    chk("ignored_consume", 128'(o_brick_avail), 128'(1));
    consume();
    chk("avail_drained", 128'(o_brick_avail), 128'(0));

    // Pops, including pops of empty lanes.
    pop(0);
    chk("pop_occ1", 128'(occ_of(0)), 128'(1));
    pop(0);
    chk("pop_occ0", 128'(occ_of(0)), 128'(0));
    pop(0);
    chk("pop_empty_lane0", 128'(occ_of(0)), 128'(0));
    pop(1);
    chk("pop_empty_lane1", 128'(occ_of(1)), 128'(0));
    chk("all_empty", 128'(o_occupancy), 128'(0));

    // Fill lane 3, then pop with a held beat that wraps to address 0.
    for (int i = 0; i < 64; i++)
      send(3, 1'b0, 1'b0, 16'(16'h3000 + i), i[3:0], i[5:0], 1'b1);
    chk("lane3_full_occ", 128'(occ_of(3)), 128'(64));
    chk("lane3_full_ready", 128'(o_ready[3]), 128'(0));
    i_valid[3] = 1'b1;
    i_data[3*16 +: 16] = 16'h3ABC;
    i_offset[3*4 +: 4] = 4'h5;
    i_pop[3] = 1'b1;
    exp_q.push_back({4'd3, 6'd0, 16'h3ABC, 4'h5});
    @(posedge clk); #1;
    chk("full_pop_no_accept", 128'(occ_of(3)), 128'(63));
    chk("full_pop_no_wen", 128'(o_nbin_wen[3]), 128'(0));
    i_pop[3] = 1'b0;
    @(posedge clk); #1;
    i_valid[3] = 1'b0;
    chk("wrap_accept_occ", 128'(occ_of(3)), 128'(64));
    chk("wrap_accept_wen", 128'(o_nbin_wen[3]), 128'(1));
    pop(3);
    chk("lane3_occ63", 128'(occ_of(3)), 128'(63));

    // Lane 5 saturates its brick counter.
    send(5, 1'b1, 1'b0, 16'h5001, 4'd1, 6'd0, 1'b1);
    send(5, 1'b1, 1'b0, 16'h5002, 4'd2, 6'd1, 1'b1);
    send(5, 1'b1, 1'b0, 16'h5003, 4'd3, 6'd2, 1'b1);
    chk("bcnt_full_ready", 128'(o_ready[5]), 128'(0));
    chk("lane5_occ3", 128'(occ_of(5)), 128'(3));
    null_beats(16'hFFDF);
    chk("avail_lane5_case", 128'(o_brick_avail), 128'(1));
    consume();
    chk("lane5_ready_again", 128'(o_ready[5]), 128'(1));
    chk("avail_after_lane5_consume", 128'(o_brick_avail), 128'(0));
    null_beats(16'hFFDF);
    chk("avail_before_combined", 128'(o_brick_avail), 128'(1));
    // Last beat and consume together: lane 5 stays at two bricks.
    chk("ready_before_combined", 128'(o_ready[5]), 128'(1));
    i_valid[5] = 1'b1;
    i_last[5]  = 1'b1;
    i_data[5*16 +: 16] = 16'h5004;
    i_offset[5*4 +: 4] = 4'd4;
    i_brick_consume = 1'b1;
    exp_q.push_back({4'd5, 6'd3, 16'h5004, 4'd4});
    @(posedge clk); #1;
    i_valid[5] = 1'b0;
    i_last[5]  = 1'b0;
    i_brick_consume = 1'b0;
    chk("combined_avail", 128'(o_brick_avail), 128'(0));
    chk("combined_ready", 128'(o_ready[5]), 128'(1));
    send(5, 1'b1, 1'b0, 16'h5005, 4'd5, 6'd4, 1'b1);
    chk("combined_bcnt_unchanged", 128'(o_ready[5]), 128'(0));
    chk("lane5_occ5", 128'(occ_of(5)), 128'(5));

    // Null flag without last is an ordinary data beat.
    send(6, 1'b0, 1'b1, 16'h6666, 4'd2, 6'd0, 1'b1);
    chk("null_no_last_occ", 128'(occ_of(6)), 128'(1));

    // Mid-brick asynchronous reset with lane 2 at five entries.
    for (int i = 0; i < 5; i++)
      send(2, 1'b0, 1'b0, 16'(16'h2000 + i), i[3:0], i[5:0], 1'b1);
    chk("lane2_occ5", 128'(occ_of(2)), 128'(5));
    @(negedge clk); #1;
    i_valid[2] = 1'b1;
    i_data[2*16 +: 16] = 16'h2BAD;
    i_offset[2*4 +: 4] = 4'd8;
    chk("wen_before_reset", 128'(o_nbin_wen), 128'(16'h0004));
    rst = 1'b0;
    #1;
    chk("rst_nbin_wen", 128'(o_nbin_wen), 128'(0));
    chk("rst_off_wen", 128'(o_off_wen), 128'(0));
    chk("rst_nbin_data", 128'(o_nbin_data), 128'(0));
    chk("rst_offset_data", 128'(o_offset_data), 128'(0));
    chk("rst_nbin_addr", 128'(o_nbin_addr), 128'(0));
    chk("rst_off_addr", 128'(o_off_wr_addr), 128'(0));
    chk("rst_occ", 128'(o_occupancy), 128'(0));
    chk("rst_avail", 128'(o_brick_avail), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    i_data[2*16 +: 16] = 16'h2BEE;
    i_offset[2*4 +: 4] = 4'd9;
    exp_q.push_back({4'd2, 6'd0, 16'h2BEE, 4'd9});
    @(posedge clk); #1;
    chk("ready_after_release", 128'(o_ready), 128'(16'hFFFF));
    chk("no_accept_while_not_ready", 128'(o_nbin_wen), 128'(0));
    @(posedge clk); #1;
    i_valid[2] = 1'b0;
    chk("post_reset_occ", 128'(occ_of(2)), 128'(1));
    chk("post_reset_wen", 128'(o_nbin_wen), 128'(16'h0004));
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
